// File: rtl/booth_mul8_pkg.sv
// booth_mul8_pkg
// Shared constants for the radix-2 Booth multiplier slice:
//   OP_W    operand width (two's complement multiplicand/multiplier)
//   ACC_W   accumulator width, one guard bit above OP_W so -128 never overflows
//   PROD_W  product width
//   ITER    number of Booth steps per multiply
//   CNT_W   width of the step counter
//   ST_*    control FSM state encoding
package booth_mul8_pkg;

   localparam int OP_W   = 8;
   localparam int ACC_W  = OP_W + 1;
   localparam int PROD_W = 2 * OP_W;
   localparam int ITER   = 8;
   localparam int CNT_W  = $clog2(ITER);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_ctrl.sv
// booth_ctrl
// Control FSM and step counter for the Booth multiplier. Decides when the
// datapath loads operands, which Booth operation the current step performs
// and when the last step is taken.
//   clk, rst   clock and synchronous active-high reset
//   start      multiply request, only honoured in IDLE
//   q0, q_1    the Booth pair {Q[0], Q_-1} from the datapath
//   ready      high in IDLE
//   busy       high in CALC
//   done       high in DONE (one cycle)
//   load       operand capture strobe
//   add, sub   accumulator add/subtract strobes for the current step
//   shift      arithmetic-shift strobe, asserted on every CALC step
//   last_step  the current CALC step is the final one
module booth_ctrl
   import booth_mul8_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic q0,
   input  logic q_1,
   output logic ready,
   output logic busy,
   output logic done,
   output logic load,
   output logic add,
   output logic sub,
   output logic shift,
   output logic last_step
);

   logic [1:0]       state;
   logic [CNT_W-1:0] count;

   // State and step counter. The counter only advances while calculating;
   // reaching the final count hands over to DONE, which always returns to
   // IDLE one cycle later regardless of start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_CALC;
                  count <= '0;
               end
            end
            ST_CALC: begin
               count <= count + 1'b1;
               if (count == CNT_W'(ITER - 1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               count <= '0;
            end
         endcase
      end
   end

   // Status flags and datapath strobes are pure decodes of the state, the
   // counter and the Booth pair, so the datapath acts on the same edge.
   always_comb begin
      ready     = (state == ST_IDLE);
      busy      = (state == ST_CALC);
      done      = (state == ST_DONE);
      load      = ready && start;
      shift     = busy;
      add       = busy && ({q0, q_1} == 2'b01);
      sub       = busy && ({q0, q_1} == 2'b10);
      last_step = busy && (count == CNT_W'(ITER - 1));
   end

endmodule

// File: rtl/booth_mux2.sv
// booth_mux2
// One-bit 2:1 selector cell used to build the per-bit next-state muxes of
// the Booth datapath.
//   d0   value passed when sel = 0
//   d1   value passed when sel = 1
//   sel  select
//   y    selected value
module booth_mux2 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/booth_mul8.sv
// booth_mul8
// Sequential 8x8 signed radix-2 Booth multiplier. One Booth step per clock,
// eight steps per multiply, product registered on the final step and held
// until the next accepted start.
//   clk      system clock
//   rst      synchronous active-high reset, aborts any operation
//   start    multiply request, sampled only while ready
//   a, b     two's-complement multiplicand / multiplier, captured on accept
//   ready    idle and able to accept start
//   busy     Booth steps in progress
//   done     one-cycle pulse, product is new
//   product  signed 16-bit a*b
module booth_mul8
   import booth_mul8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   localparam int AQ_W = ACC_W + OP_W;

   logic [ACC_W-1:0]  acc_q;
   logic [OP_W-1:0]   mq_q;
   logic              q_1_q;
   logic [ACC_W-1:0]  m_q;

   logic              load;
   logic              add;
   logic              sub;
   logic              shift;
   logic              last_step;

   logic [ACC_W-1:0]  acc_sum;
   logic [ACC_W-1:0]  step_acc;
   logic [OP_W-1:0]   step_q;
   logic [AQ_W-1:0]   hold_load_aq;
   logic [AQ_W-1:0]   step_aq;
   logic [AQ_W-1:0]   next_aq;
   logic [ACC_W-1:0]  next_m;
   logic              next_q_1;

   booth_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .q0        (mq_q[0]),
      .q_1       (q_1_q),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .load      (load),
      .add       (add),
      .sub       (sub),
      .shift     (shift),
      .last_step (last_step)
   );

   // One Booth step: optional add/subtract of the 9-bit multiplicand, then an
   // arithmetic right shift of {A, Q, Q_-1}. The guard bit keeps A-M correct
   // when M is -128.
   always_comb begin
      acc_sum = acc_q;
      if (add) begin
         acc_sum = acc_q + m_q;
      end else if (sub) begin
         acc_sum = acc_q - m_q;
      end
      step_acc = {acc_sum[ACC_W-1], acc_sum[ACC_W-1:1]};
      step_q   = {acc_sum[0], mq_q[OP_W-1:1]};
   end

   // Value of {A, Q} when no step is taken: fresh operands on load, otherwise
   // the registers simply hold.
   always_comb begin
      hold_load_aq = {acc_q, mq_q};
      if (load) begin
         hold_load_aq = {{ACC_W{1'b0}}, b};
      end
      step_aq = {step_acc, step_q};
   end

   // Per-bit selection between the hold/load value and the stepped value.
   for (genvar i = 0; i < AQ_W; i++) begin : g_aq_mux
      booth_mux2 u_mux (
         .d0  (hold_load_aq[i]),
         .d1  (step_aq[i]),
         .sel (shift),
         .y   (next_aq[i])
      );
   end

   // Multiplicand and the Booth history bit only change on load or step.
   always_comb begin
      next_m   = m_q;
      next_q_1 = q_1_q;
      if (load) begin
         next_m   = {a[OP_W-1], a};
         next_q_1 = 1'b0;
      end else if (shift) begin
         next_q_1 = mq_q[0];
      end
   end

   // Datapath registers. Reset clears everything, including the product, so
   // an aborted multiply never leaves a stale result visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         mq_q    <= '0;
         q_1_q   <= 1'b0;
         m_q     <= '0;
         product <= '0;
      end else begin
         acc_q <= next_aq[AQ_W-1:OP_W];
         mq_q  <= next_aq[OP_W-1:0];
         q_1_q <= next_q_1;
         m_q   <= next_m;
         if (last_step) begin
            product <= {step_acc[OP_W-1:0], step_q};
         end
      end
   end

endmodule

// File: tb/tb_booth_mul8.sv
// tb_booth_mul8
// Directed self-checking bench for booth_mul8: reset state, hand-computed
// vectors, corner operands, start held high, rst racing start and an abort
// in the middle of a calculation.
module tb_booth_mul8;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int checkCount;
   int errorCount;

   booth_mul8 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the DUT never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference signed product.
   function automatic logic [15:0] refProd(input logic signed [7:0] x, input logic signed [7:0] y);
      int px;
      int py;
      px = x;
      py = y;
      return 16'(px * py);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Bounded wait for IDLE, entered and left on a falling edge.
   task automatic waitIdle(input string tag);
      for (int i = 0; i < 30 && !ready; i++) begin
         @(negedge clk);
      end
      checkOutput({tag, " idle"}, 32'(ready), 32'd1);
   endtask

   // One full multiply from IDLE: accept, disturb the operands, measure the
   // latency to done, check the product, the pulse width and the hold.
   task automatic applyStimulus(input string tag, input logic signed [7:0] opA,
                                input logic signed [7:0] opB, input logic [15:0] expProd);
      int lat;
      bit seen;
      a     = opA;
      b     = opB;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = ~opA;
      b     = opB + 8'd37;
      lat   = 0;
      seen  = 1'b0;
      for (int i = 1; i <= 12 && !seen; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checkOutput({tag, " calc flags"}, 32'({ready, busy, done}), 32'b010);
         end
         if (done) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'd8);
      checkOutput({tag, " product"}, 32'(product), 32'(expProd));
      @(negedge clk);
      checkOutput({tag, " after done"}, 32'({ready, busy, done}), 32'b100);
      checkOutput({tag, " held"}, 32'(product), 32'(expProd));
   endtask

   initial begin
      logic signed [7:0] corners [5];
      logic [7:0] rx;
      logic [7:0] ry;
      int pulses;
      int firstAt;
      int lastAt;
      int badProd;

      checkCount = 0;
      errorCount = 0;
      corners    = '{-8'sd128, -8'sd1, 8'sd0, 8'sd1, 8'sd127};

      // Reset state.
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset flags", 32'({ready, busy, done}), 32'b100);
      checkOutput("reset product", 32'(product), 32'h0);

      // Hand-computed vectors.
      applyStimulus("3x5",       8'sd3,    8'sd5,    16'h000F);
      applyStimulus("-128x-128", -8'sd128, -8'sd128, 16'h4000);
      applyStimulus("127x-128",  8'sd127,  -8'sd128, 16'hC080);
      applyStimulus("-1x1",      -8'sd1,   8'sd1,    16'hFFFF);
      applyStimulus("-7x9",      -8'sd7,   8'sd9,    16'hFFC1);
      applyStimulus("100x-3",    8'sd100,  -8'sd3,   16'hFED4);
      applyStimulus("0x-55",     8'sd0,    -8'sd55,  16'h0000);

      // rst and start in the same cycle: rst wins.
      applyStimulus("9x9", 8'sd9, 8'sd9, 16'h0051);
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'd5;
      b     = 8'd5;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      checkOutput("rst+start flags", 32'({ready, busy, done}), 32'b100);
      checkOutput("rst+start product", 32'(product), 32'h0);
      @(negedge clk);
      checkOutput("rst+start stays idle", 32'({ready, busy, done}), 32'b100);

      // start held high: one done pulse every 10 cycles.
      a       = 8'd3;
      b       = 8'd5;
      start   = 1'b1;
      pulses  = 0;
      firstAt = -1;
      lastAt  = -1;
      badProd = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            pulses++;
            if (firstAt < 0) firstAt = i;
            lastAt = i;
            if (product !== 16'h000F) badProd++;
         end
      end
      start = 1'b0;
      checkOutput("held pulses", 32'(pulses), 32'd3);
      checkOutput("held first", 32'(firstAt), 32'd8);
      checkOutput("held spacing", 32'(lastAt - firstAt), 32'd20);
      checkOutput("held product", 32'(badProd), 32'd0);
      waitIdle("held");

      // Corner operand set, all 25 pairs.
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            applyStimulus($sformatf("corner %0d*%0d", corners[i], corners[j]),
                          corners[i], corners[j], refProd(corners[i], corners[j]));
         end
      end

      // Random operand pairs against the reference product.
      for (int k = 0; k < 300; k++) begin
         rx = 8'($urandom);
         ry = 8'($urandom);
         applyStimulus($sformatf("rand %0h*%0h", rx, ry), rx, ry, refProd(rx, ry));
      end

      // Abort in the middle of a calculation.
      a     = 8'd3;
      b     = 8'd5;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort flags", 32'({ready, busy, done}), 32'b100);
      checkOutput("abort product", 32'(product), 32'h0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      checkOutput("abort no activity", 32'(pulses), 32'd0);
      applyStimulus("6x-7", 8'sd6, -8'sd7, 16'hFFD6);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
